// File: rtl/srrc_lut_interp_flt.sv
// LUT-based SRRC pulse-shaping interpolator for 4-level PAM: zero-stuffed symbol line,
// precomputed +1h/+3h taps, registered adder tree, saturated output and double-buffered coefficients.
module srrc_lut_interp_flt #(
  parameter int NTAPS = 121,
  parameter int OSR   = 4,
  parameter int DW    = 18,
  parameter int AW    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sam_clk_en,
  input  logic                 sym_clk_en,
  input  logic [1:0]           sym_in,
  input  logic                 coef_we,
  input  logic                 coef_sel,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [DW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 coef_busy,
  output logic signed [DW-1:0] out,
  output logic                 out_valid,
  output logic                 sat
);
  localparam int LG  = $clog2(NTAPS);
  localparam int LAT = LG + 2;
  localparam int SW  = DW + LG;
  localparam int NT2 = NTAPS + 1;
  localparam int CW  = $clog2(LAT + 1);
  localparam int KW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0]        LAT_M1 = CW'(LAT - 1);
  localparam logic signed [SW-1:0] SMAX   = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN   = SW'(-(1 << (DW - 1)));

  typedef enum logic {IDLE, PEND} swap_state_t;

  logic [2:0]                 line [NTAPS];
  logic signed [DW-1:0]       t1 [2][NTAPS];
  logic signed [DW-1:0]       t3 [2][NTAPS];
  logic signed [SW-1:0]       tree [LG+1][NT2];
  logic                       act;
  swap_state_t                state;
  logic [CW-1:0]              cnt;
  logic [KW-1:0]              waddr;
  logic signed [SW-1:0]       sum;

  assign waddr = coef_addr[KW-1:0];
  assign sum   = tree[LG][0];

  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
    if (v == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    else return -v;
  endfunction

  // Entry {valid, idx}: pick the |level| table, apply the sign, invalid entries give zero.
  function automatic logic signed [SW-1:0] tap_val(input logic [2:0] e,
                                                   input logic signed [DW-1:0] c1,
                                                   input logic signed [DW-1:0] c3);
    logic signed [DW-1:0] mag;
    logic signed [DW-1:0] v;
    mag = (e[1] == e[0]) ? c3 : c1;
    v   = e[1] ? mag : neg_sat(mag);
    return e[2] ? {{LG{v[DW-1]}}, v} : '0;
  endfunction

  function automatic int stage_cnt(input int s);
    return (NTAPS + (1 << s) - 1) >> s;
  endfunction

  // Zero-stuffing symbol delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) line[k] <= 3'b000;
    end else if (sam_clk_en) begin
      line[0] <= sym_clk_en ? {1'b1, sym_in} : 3'b000;
      for (int k = 1; k < NTAPS; k++) line[k] <= line[k-1];
    end
  end

  // Shadow-bank writes; the active bank is read-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NTAPS; k++) begin
          t1[b][k] <= '0;
          t3[b][k] <= '0;
        end
      end
    end else if (coef_we && !coef_busy && (int'(coef_addr) < NTAPS)) begin
      if (coef_sel) t3[!act][waddr] <= coef_data;
      else          t1[!act][waddr] <= coef_data;
    end
  end

  // Bank swap FSM: the pointer flips only on an enable that carries a symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      act       <= 1'b0;
      coef_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_swap) begin
            state     <= PEND;
            coef_busy <= 1'b1;
          end
        end
        PEND: begin
          if (sam_clk_en && sym_clk_en) begin
            state     <= IDLE;
            coef_busy <= 1'b0;
            act       <= !act;
          end
        end
        default: begin
          state     <= IDLE;
          coef_busy <= 1'b0;
        end
      endcase
    end
  end

  // Lookup register, pairwise adder tree, saturation and priming counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= LG; s++)
        for (int i = 0; i < NT2; i++) tree[s][i] <= '0;
      out       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (sam_clk_en) begin
      for (int k = 0; k < NTAPS; k++) tree[0][k] <= tap_val(line[k], t1[act][k], t3[act][k]);
      tree[0][NT2-1] <= '0;
      for (int s = 1; s <= LG; s++) begin
        for (int i = 0; i < NT2 / 2; i++) begin
          if (2 * i + 1 < stage_cnt(s - 1))  tree[s][i] <= tree[s-1][2*i] + tree[s-1][2*i+1];
          else if (2 * i < stage_cnt(s - 1)) tree[s][i] <= tree[s-1][2*i];
          else                               tree[s][i] <= '0;
        end
      end
      if (sum > SMAX) begin
        out <= {1'b0, {(DW-1){1'b1}}};
        sat <= 1'b1;
      end else if (sum < SMIN) begin
        out <= {1'b1, {(DW-1){1'b0}}};
        sat <= 1'b1;
      end else begin
        out <= sum[DW-1:0];
      end
      if (cnt < LAT_M1) cnt <= cnt + 1'b1;
      else              out_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_srrc_lut_interp_flt.sv
// Self-checking bench for srrc_lut_interp_flt: directed tables and hand sequences plus random
// stimulus compared against a per-clock behavioural model of the transmit filter.
module tb_srrc_lut_interp_flt;
  localparam int NTAPS = 5, OSR = 4, DW = 18, AW = 7, LAT = 5;
  localparam int MAXV = 131071, MINV = -131072;

  logic                 clk = 1'b0;
  logic                 reset, sam_clk_en, sym_clk_en;
  logic [1:0]           sym_in;
  logic                 coef_we, coef_sel, coef_swap;
  logic [AW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 coef_busy, out_valid, sat;
  logic signed [DW-1:0] out;

  int n_pass = 0, n_total = 0;

  srrc_lut_interp_flt #(.NTAPS(NTAPS), .OSR(OSR), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .sym_in(sym_in), .coef_we(coef_we), .coef_sel(coef_sel), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_swap(coef_swap), .coef_busy(coef_busy),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  // Behavioural model: symbol levels in a delay line, sums delayed LAT-1 enables, then clipped.
  bit m_v[NTAPS];
  int m_lv[NTAPS];
  int m_t[2][2][NTAPS];
  int m_act, m_out, m_cnt;
  bit m_pend, m_valid, m_sat;
  int m_q[$];

  typedef struct { logic symv; logic [1:0] sym; int exp_out; logic exp_valid; logic exp_sat; } vec_t;
  vec_t tv[22];

  function automatic int lvl(input logic [1:0] i);
    case (i)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b10:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int clip(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int contrib(input int c, input int l);
    if (l > 0) return c;
    return (c == MINV) ? MAXV : -c;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      m_v[k] = 1'b0; m_lv[k] = 0;
      for (int b = 0; b < 2; b++) begin m_t[b][0][k] = 0; m_t[b][1][k] = 0; end
    end
    m_act = 0; m_pend = 1'b0; m_out = 0; m_valid = 1'b0; m_sat = 1'b0; m_cnt = 0;
    m_q.delete();
    for (int i = 0; i < LAT - 1; i++) m_q.push_back(0);
  endtask

  task automatic tick(input logic t_sam, input logic t_sym, input logic [1:0] t_idx,
                      input logic t_we, input logic t_sel, input logic [AW-1:0] t_addr,
                      input int t_data, input logic t_swap, input logic t_rst);
    int s, p, l;
    reset = t_rst; sam_clk_en = t_sam; sym_clk_en = t_sym; sym_in = t_idx;
    coef_we = t_we; coef_sel = t_sel; coef_addr = t_addr; coef_data = DW'(t_data);
    coef_swap = t_swap;
    @(posedge clk);
    if (t_rst) model_reset();
    else begin
      if (t_sam) begin
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
          l = m_lv[k];
          if (m_v[k]) s += contrib(m_t[m_act][(l == 3 || l == -3) ? 1 : 0][k], l);
        end
        m_q.push_back(s);
        p = m_q.pop_front();
        m_out = clip(p);
        if (p != m_out) m_sat = 1'b1;
        m_cnt++;
        if (m_cnt >= LAT) m_valid = 1'b1;
        for (int k = NTAPS - 1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_lv[k] = m_lv[k-1]; end
        m_v[0] = t_sym; m_lv[0] = lvl(t_idx);
      end
      if (t_we && !m_pend && int'(t_addr) < NTAPS) m_t[1-m_act][t_sel ? 1 : 0][t_addr] = t_data;
      if (m_pend) begin
        if (t_sam && t_sym) begin m_act = 1 - m_act; m_pend = 1'b0; end
      end else if (t_swap) m_pend = 1'b1;
    end
    #1;
    check("model out", int'(out), m_out);
    check("model out_valid", int'(out_valid), int'(m_valid));
    check("model sat", int'(sat), int'(m_sat));
    check("model coef_busy", int'(coef_busy), int'(m_pend));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic samp(input logic s, input logic [1:0] i);
    tick(1'b1, s, i, 1'b0, 1'b0, 7'd0, 0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic wr(input logic sel, input logic [AW-1:0] a, input int v);
    tick(1'b0, 1'b0, 2'b00, 1'b1, sel, a, v, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd0, 0, 1'b0, 1'b1);
  endtask

  task automatic swap_req();
    tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int e4[10];
    int rv;
    logic r_sam, r_sym;

    for (int i = 0; i < 22; i++) begin
      tv[i].symv = 1'b0; tv[i].sym = 2'b00; tv[i].exp_out = 0;
      tv[i].exp_valid = (i >= 4); tv[i].exp_sat = 1'b0;
    end
    tv[0].symv = 1'b1;  tv[0].sym = 2'b10;
    tv[11].symv = 1'b1; tv[11].sym = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tv[5 + k].exp_out  = k + 1;
      tv[16 + k].exp_out = -10 * (k + 1);
    end

    model_reset();
    rst_pulse();
    check("reset out", int'(out), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset sat", int'(sat), 0);
    check("reset coef_busy", int'(coef_busy), 0);

    // Tests 1 and 2: +1 then -3 impulses through freshly loaded tables.
    for (int k = 0; k < NTAPS; k++) begin
      wr(1'b0, AW'(k), k + 1);
      wr(1'b1, AW'(k), 10 * (k + 1));
    end
    swap_req();
    check("swap busy", int'(coef_busy), 1);
    for (int i = 0; i < 22; i++) begin
      samp(tv[i].symv, tv[i].sym);
      check($sformatf("impulse out e%0d", i + 1), int'(out), tv[i].exp_out);
      check($sformatf("impulse valid e%0d", i + 1), int'(out_valid), int'(tv[i].exp_valid));
      check($sformatf("impulse sat e%0d", i + 1), int'(sat), int'(tv[i].exp_sat));
    end

    // Test 3: two overlapping +3 symbols clip; a single full-scale tap does not.
    for (int k = 0; k < NTAPS; k++) wr(1'b1, AW'(k), MAXV);
    swap_req();
    for (int j = 0; j < 14; j++) begin
      samp(j == 0 || j == 4, 2'b11);
      check($sformatf("clip out j%0d", j), int'(out), (j >= 5) ? MAXV : 0);
      check($sformatf("clip sat j%0d", j), int'(sat), (j >= 9) ? 1 : 0);
    end
    rst_pulse();
    check("post-clip reset sat", int'(sat), 0);
    check("post-clip reset out", int'(out), 0);

    // Test 4: swap requested mid-symbol; write while busy is dropped.
    samp(1'b1, 2'b10); samp(1'b0, 2'b00); samp(1'b0, 2'b00); samp(1'b0, 2'b00);
    samp(1'b1, 2'b10); samp(1'b0, 2'b00); samp(1'b0, 2'b00); samp(1'b0, 2'b00);
    samp(1'b1, 2'b10); samp(1'b0, 2'b00);
    for (int k = 0; k < NTAPS; k++) begin wr(1'b0, AW'(k), 7); wr(1'b1, AW'(k), 7); end
    swap_req();
    check("mid-symbol busy", int'(coef_busy), 1);
    wr(1'b0, 7'd0, 100);
    check("busy after write", int'(coef_busy), 1);
    samp(1'b0, 2'b00);
    check("busy before boundary a", int'(coef_busy), 1);
    samp(1'b0, 2'b00);
    check("busy before boundary b", int'(coef_busy), 1);
    samp(1'b1, 2'b10);
    check("busy after boundary", int'(coef_busy), 0);
    e4 = '{0, 0, 0, 0, 14, 7, 7, 7, 7, 0};
    for (int j = 0; j < 10; j++) begin
      samp(1'b0, 2'b00);
      check($sformatf("swap out j%0d", j + 1), int'(out), e4[j]);
    end

    // Test 5: out-of-range write dropped; write in the swap clock lands before the flip.
    wr(1'b0, 7'd5, 999);
    tick(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd2, 55, 1'b1, 1'b0);
    check("we+swap busy", int'(coef_busy), 1);
    samp(1'b0, 2'b00);
    samp(1'b1, 2'b10);
    for (int j = 1; j <= 10; j++) begin
      samp(1'b0, 2'b00);
      check($sformatf("we+swap out j%0d", j), int'(out), (j == 7) ? 55 : 0);
    end

    // Test 6: reset mid-stream clears pipeline, priming counter and both banks.
    for (int j = 0; j < 12; j++) samp(j % 4 == 0, 2'($urandom_range(0, 3)));
    rst_pulse();
    check("midstream reset out", int'(out), 0);
    check("midstream reset valid", int'(out_valid), 0);
    for (int j = 1; j <= 8; j++) begin
      samp(j % 4 == 1, 2'($urandom_range(0, 3)));
      check($sformatf("reprime valid e%0d", j), int'(out_valid), (j >= 5) ? 1 : 0);
      check($sformatf("cleared bank out e%0d", j), int'(out), 0);
    end
    swap_req();
    samp(1'b1, 2'b11);
    for (int j = 0; j < 8; j++) begin
      samp(j % 4 == 3, 2'b00);
      check($sformatf("cleared other bank out j%0d", j), int'(out), 0);
    end

    // Random traffic against the model, including extreme coefficients and rare resets.
    for (int n = 0; n < 4000; n++) begin
      r_sam = 1'($urandom_range(0, 1));
      r_sym = r_sam ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       rv = MINV;
        1:       rv = MAXV;
        default: rv = int'($urandom_range(0, 40000)) - 20000;
      endcase
      tick(r_sam, r_sym, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), rv,
           $urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
